// File: rtl/sha_pkg.sv
// ---------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA message block padder:
//   state_t          - padder FSM states (IDLE, READ, WAIT, EMIT)
//   BLOCK_WORDS      - 32-bit words per 512-bit block
//   LEN_BYTES        - bytes of bit-length field at the tail of the final block
//   calc_num_blocks  - number of padded blocks for a message of 'size' bytes
// ---------------------------------------------------------------------------
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam int BLOCK_WORDS = 16;
  localparam int LEN_BYTES   = 8;

  // floor((size*8 + 64) / 512) + 1 reduces to floor((size + 8) / 64) + 1.
  // The sum is formed in 33 bits so sizes near 2^32 cannot wrap.
  function automatic logic [31:0] calc_num_blocks(input logic [31:0] size);
    logic [32:0] padded;
    padded = {1'b0, size} + 33'(LEN_BYTES);
    return 32'(padded >> 6) + 32'd1;
  endfunction

endpackage

// File: rtl/sha_block_padder_if.sv
// ---------------------------------------------------------------------------
// sha_block_padder_if
// Bundles the padder's command, memory-read and block-stream signals.
//   start, message_addr, size     - command from the requester
//   mem_addr, mem_read_data       - word-addressed memory read port
//                                   (data valid one cycle after address)
//   blk_valid, blk_ready,
//   blk_data, blk_last            - padded 512-bit block stream
//   num_blocks, busy              - status
// Modports:
//   master - the padder itself
//   slave  - the environment (requester, memory and block consumer)
// ---------------------------------------------------------------------------
interface sha_block_padder_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [31:0]       size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_read_data;
  logic              blk_valid;
  logic              blk_ready;
  logic [511:0]      blk_data;
  logic              blk_last;
  logic [15:0]       num_blocks;
  logic              busy;

  modport master (
    input  start, message_addr, size, mem_read_data, blk_ready,
    output mem_addr, blk_valid, blk_data, blk_last, num_blocks, busy
  );

  modport slave (
    output start, message_addr, size, mem_read_data, blk_ready,
    input  mem_addr, blk_valid, blk_data, blk_last, num_blocks, busy
  );
endinterface

// File: rtl/sha_word_builder.sv
// ---------------------------------------------------------------------------
// sha_word_builder
// Combinational: forms one padded 32-bit word of the SHA stream.
// Ports:
//   raw_word  in  32  memory word (already in big-endian byte order)
//   word_idx  in  32  global word index within the padded stream
//   size      in  32  message length in bytes
//   final_blk in  1   word belongs to the last block of the message
//   word      out 32  padded word
// Bytes below 'size' come from raw_word, the byte at 'size' is 0x80, the
// rest are zero; in the final block the last two words carry the 64-bit
// big-endian message bit length instead.
// ---------------------------------------------------------------------------
module sha_word_builder
  import sha_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [31:0] word_idx,
  input  logic [31:0] size,
  input  logic        final_blk,
  output logic [31:0] word
);

  localparam logic [3:0] LEN_HI_WORD = 4'(BLOCK_WORDS - LEN_BYTES / 4);
  localparam logic [3:0] LEN_LO_WORD = 4'(BLOCK_WORDS - 1);

  logic [33:0] byte_pos;

  always_comb begin
    word     = '0;
    byte_pos = '0;
    for (int j = 0; j < 4; j++) begin
      byte_pos = {word_idx, 2'b00} + 34'(j);
      if (byte_pos < {2'b00, size}) begin
        word[31-8*j -: 8] = raw_word[31-8*j -: 8];
      end else if (byte_pos == {2'b00, size}) begin
        word[31-8*j -: 8] = 8'h80;
      end
    end
    // The block count formula guarantees these two words never hold
    // message or 0x80 bytes in the final block, so overriding is safe.
    if (final_blk && (word_idx[3:0] == LEN_HI_WORD)) begin
      word = {29'b0, size[31:29]};
    end else if (final_blk && (word_idx[3:0] == LEN_LO_WORD)) begin
      word = {size[28:0], 3'b000};
    end
  end

endmodule

// File: rtl/sha_block_padder.sv
// ---------------------------------------------------------------------------
// sha_block_padder
// Reads a byte message from word-addressed memory and emits it as a stream
// of SHA-style padded 512-bit blocks (0x80 terminator, zero fill, 64-bit
// big-endian bit length at the end of the final block).
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      sha_block_padder_if.master (command, memory, block stream)
// Each word takes two cycles (READ issues the address, WAIT captures the
// returned data), so a block costs 32 cycles plus one EMIT cycle.
// Words that contain no message byte never change mem_addr, i.e. no read.
// Build option: define PADDER_BYTE_SWAP_EN for little-endian memory; each
// read word is then byte-reversed before use.
// ---------------------------------------------------------------------------
module sha_block_padder
  import sha_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha_block_padder_if.master   bus
);

  state_t            state, state_nxt;

  logic [31:0]       size_q;
  logic [31:0]       total_blk;
  logic [31:0]       blk_cnt;
  logic [3:0]        word_idx;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       words_q [BLOCK_WORDS];
  logic              blk_valid_q;
  logic              blk_last_q;
  logic              busy_q;
  logic [15:0]       num_blocks_q;

  logic [31:0]       msg_words;
  logic [31:0]       gword;
  logic [31:0]       gword_nxt;
  logic              next_needs_read;
  logic              final_blk;
  logic              handshake;
  logic [31:0]       raw_word;
  logic [31:0]       built_word;
  logic [511:0]      blk_data_w;

  // Number of memory words that hold at least one message byte.
  assign msg_words       = (size_q >> 2) + {31'b0, |size_q[1:0]};
  // Block counts stay below 2^27, so 28 bits of block index suffice.
  assign gword           = {blk_cnt[27:0], word_idx};
  // Holds for both in-block advance and the wrap into the next block,
  // because word_idx is 15 whenever a block is being emitted.
  assign gword_nxt       = gword + 32'd1;
  assign next_needs_read = (gword_nxt < msg_words);
  assign final_blk       = (blk_cnt == total_blk - 32'd1);
  assign handshake       = (state == EMIT) && bus.blk_ready;

`ifdef PADDER_BYTE_SWAP_EN
  assign raw_word = {bus.mem_read_data[7:0],   bus.mem_read_data[15:8],
                     bus.mem_read_data[23:16], bus.mem_read_data[31:24]};
`else
  assign raw_word = bus.mem_read_data;
`endif

  sha_word_builder u_word_builder (
    .raw_word  (raw_word),
    .word_idx  (gword),
    .size      (size_q),
    .final_blk (final_blk),
    .word      (built_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = READ;
      READ: state_nxt = WAIT;
      WAIT: begin
        if (word_idx == 4'(BLOCK_WORDS - 1)) state_nxt = EMIT;
        else                                 state_nxt = READ;
      end
      EMIT: begin
        if (handshake) state_nxt = blk_last_q ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q       <= '0;
      total_blk    <= '0;
      blk_cnt      <= '0;
      word_idx     <= '0;
      base_addr    <= '0;
      mem_addr_q   <= '0;
      blk_valid_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      num_blocks_q <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) words_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start is only honoured here, so a start while busy is dropped.
          if (bus.start) begin
            size_q       <= bus.size;
            base_addr    <= bus.message_addr;
            total_blk    <= calc_num_blocks(bus.size);
            num_blocks_q <= 16'(calc_num_blocks(bus.size));
            blk_cnt      <= '0;
            word_idx     <= '0;
            busy_q       <= 1'b1;
            if (bus.size != 32'd0) mem_addr_q <= bus.message_addr;
          end
        end
        WAIT: begin
          words_q[word_idx] <= built_word;
          if (word_idx == 4'(BLOCK_WORDS - 1)) begin
            blk_valid_q <= 1'b1;
            blk_last_q  <= final_blk;
          end else begin
            word_idx <= word_idx + 4'd1;
            if (next_needs_read) mem_addr_q <= base_addr + ADDR_W'(gword_nxt);
          end
        end
        EMIT: begin
          if (bus.blk_ready) begin
            blk_valid_q <= 1'b0;
            if (blk_last_q) begin
              blk_last_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              blk_cnt  <= blk_cnt + 32'd1;
              word_idx <= '0;
              if (next_needs_read) mem_addr_q <= base_addr + ADDR_W'(gword_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Word 0 lands in the most significant 32 bits of the block.
  always_comb begin
    blk_data_w = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      blk_data_w[511-32*i -: 32] = words_q[i];
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.blk_valid  = blk_valid_q;
  assign bus.blk_data   = blk_data_w;
  assign bus.blk_last   = blk_last_q;
  assign bus.num_blocks = num_blocks_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sha_block_padder.sv
// ---------------------------------------------------------------------------
// tb_sha_block_padder
// Self-checking bench for sha_block_padder: a byte-level reference model
// fills a scoreboard queue with expected blocks at each start; a monitor
// pops and compares on every block handshake. A vector table covers the
// main sizes; hand-written sequences cover backpressure, ignored start and
// reset in mid-message.
// ---------------------------------------------------------------------------
module tb_sha_block_padder;
  localparam int ADDR_W = 16;
  localparam int TIMEOUT = 3000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha_block_padder_if #(.ADDR_W(ADDR_W)) bus ();

  sha_block_padder #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [511:0] data;
    logic         last;
  } exp_blk_t;

  typedef struct {
    logic [31:0] size;
    logic [15:0] addr;
    int          blocks;
    logic [31:0] w15;
  } vec_t;

  exp_blk_t    sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          blocks_seen = 0;
  logic [31:0] last_w15 = '0;
  bit          hs_prev = 1'b0;
  int          cur_base = 0;
  longint      cur_words = 0;
  int          addr_bad = 0;
  logic [15:0] prev_addr = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Big-endian logical content of memory word a.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0777) return 32'hAABBCCDD;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3, a[7:0] + 8'h11, ~a[7:0]};
  endfunction

  function automatic logic [31:0] mem_bus_word(input logic [15:0] a);
    logic [31:0] w;
    w = mem_word(a);
`ifdef PADDER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always @(posedge clk) bus.mem_read_data <= mem_bus_word(bus.mem_addr);

  // Byte-level reference: build every padded byte, pack into blocks.
  task automatic push_expected(input logic [31:0] sz, input logic [15:0] base);
    longint   nblk;
    longint   b;
    longint   bitlen;
    logic [7:0]  v;
    logic [31:0] w;
    exp_blk_t e;
    nblk   = ((longint'(sz) * 8 + 64) / 512) + 1;
    bitlen = longint'(sz) * 8;
    for (longint k = 0; k < nblk; k++) begin
      e.data = '0;
      e.last = (k == nblk - 1);
      for (int bi = 0; bi < 64; bi++) begin
        b = k * 64 + bi;
        if (b < longint'(sz)) begin
          w = mem_word(16'(longint'(base) + b / 4));
          v = 8'(w >> (8 * (3 - int'(b % 4))));
        end else if (b == longint'(sz)) begin
          v = 8'h80;
        end else begin
          v = 8'h00;
        end
        if (e.last && bi >= 56) v = 8'(bitlen >> (8 * (63 - bi)));
        e.data = e.data | (512'(v) << (8 * (63 - bi)));
      end
      sb.push_back(e);
    end
  endtask

  // Block monitor: compare each handshaken block against the scoreboard.
  always @(negedge clk) begin
    if (hs_prev) check("valid_drop_after_hs", 512'(bus.blk_valid), 512'(0));
    hs_prev = 1'b0;
    if (reset_n && bus.blk_valid && bus.blk_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_block", 512'(1), 512'(0));
      end else begin
        exp_blk_t e;
        e = sb.pop_front();
        check("blk_data", bus.blk_data, e.data);
        check("blk_last", 512'(bus.blk_last), 512'(e.last));
      end
      last_w15 = bus.blk_data[31:0];
      blocks_seen++;
      hs_prev = 1'b1;
    end
  end

  // Address monitor: every new read address must fall on a message word.
  always @(negedge clk) begin
    if (bus.busy && bus.mem_addr != prev_addr) begin
      if (int'(bus.mem_addr) < cur_base || longint'(bus.mem_addr) >= longint'(cur_base) + cur_words)
        addr_bad++;
    end
    prev_addr = bus.mem_addr;
  end

  task automatic drive_start(input logic [31:0] sz, input logic [15:0] base);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.size = sz;
    bus.message_addr = base;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check("busy_timeout", 512'(1), 512'(0));
    @(negedge clk);
  endtask

  task automatic run_msg(input logic [31:0] sz, input logic [15:0] base, input int exp_blocks,
                         input logic [31:0] exp_w15, input bit inject_start);
    cur_base = int'(base);
    cur_words = (longint'(sz) + 3) / 4;
    addr_bad = 0;
    blocks_seen = 0;
    push_expected(sz, base);
    drive_start(sz, base);
    @(negedge clk);
    check("num_blocks", 512'(bus.num_blocks), 512'(exp_blocks));
    check("busy_after_start", 512'(bus.busy), 512'(1));
    if (inject_start) begin
      repeat (10) @(posedge clk);
      drive_start(32'd0, 16'h0500);
      @(negedge clk);
      check("num_blocks_ignored_start", 512'(bus.num_blocks), 512'(exp_blocks));
    end
    wait_idle();
    check("blocks_seen", 512'(blocks_seen), 512'(exp_blocks));
    check("final_word15", 512'(last_w15), 512'(exp_w15));
    check("read_addr_range", 512'(addr_bad), 512'(0));
    check("scoreboard_empty", 512'(sb.size()), 512'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_valid"}, 512'(bus.blk_valid), 512'(0));
    check({tag, "_blk_last"}, 512'(bus.blk_last), 512'(0));
    check({tag, "_busy"}, 512'(bus.busy), 512'(0));
    check({tag, "_mem_addr"}, 512'(bus.mem_addr), 512'(0));
    check({tag, "_blk_data"}, bus.blk_data, 512'(0));
    check({tag, "_num_blocks"}, 512'(bus.num_blocks), 512'(0));
  endtask

  vec_t vecs[7];

  initial begin
    bus.start = 1'b0;
    bus.size = '0;
    bus.message_addr = '0;
    bus.blk_ready = 1'b1;

    vecs[0] = '{size: 32'd0,   addr: 16'h0300, blocks: 1, w15: 32'h00000000};
    vecs[1] = '{size: 32'd120, addr: 16'h0100, blocks: 3, w15: 32'h000003C0};
    vecs[2] = '{size: 32'd511, addr: 16'h0200, blocks: 9, w15: 32'h00000FF8};
    vecs[3] = '{size: 32'd55,  addr: 16'h0040, blocks: 1, w15: 32'h000001B8};
    vecs[4] = '{size: 32'd56,  addr: 16'h0080, blocks: 2, w15: 32'h000001C0};
    vecs[5] = '{size: 32'd64,  addr: 16'h1000, blocks: 2, w15: 32'h00000200};
    vecs[6] = '{size: 32'd4,   addr: 16'hFFFE, blocks: 1, w15: 32'h00000020};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_msg(vecs[i].size, vecs[i].addr, vecs[i].blocks, vecs[i].w15, 1'b0);
    end

    // Backpressure: size 3, consumer stalls for 5 cycles.
    begin
      int n;
      logic [511:0] held;
      cur_base = 16'h0777;
      cur_words = 1;
      addr_bad = 0;
      blocks_seen = 0;
      bus.blk_ready = 1'b0;
      push_expected(32'd3, 16'h0777);
      drive_start(32'd3, 16'h0777);
      n = 0;
      while (!bus.blk_valid && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      if (n >= TIMEOUT) check("valid_timeout", 512'(1), 512'(0));
      held = bus.blk_data;
      check("size3_word0", 512'(bus.blk_data[511:480]), 512'(32'hAABBCC80));
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("stall_data", bus.blk_data, held);
        check("stall_valid", 512'(bus.blk_valid), 512'(1));
        check("stall_last", 512'(bus.blk_last), 512'(1));
      end
      @(posedge clk); #1;
      bus.blk_ready = 1'b1;
      wait_idle();
      check("stall_blocks_seen", 512'(blocks_seen), 512'(1));
      check("stall_read_addr", 512'(addr_bad), 512'(0));
    end

    // Reset during block 2 of a 9-block message, then a fresh message
    // with a start pulse injected while it is busy.
    begin
      int n;
      cur_base = 16'h0200;
      cur_words = 128;
      blocks_seen = 0;
      push_expected(32'd511, 16'h0200);
      drive_start(32'd511, 16'h0200);
      n = 0;
      while (blocks_seen < 1 && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      if (n >= TIMEOUT) check("block1_timeout", 512'(1), 512'(0));
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midmsg");
      sb.delete();
      n = blocks_seen;
      repeat (4) @(negedge clk);
      check("no_blocks_in_reset", 512'(blocks_seen), 512'(n));
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", 512'(bus.busy), 512'(0));
      run_msg(32'd120, 16'h0100, 3, 32'h000003C0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_block_padder.md
SHA_BLOCK_PADDER -- requirements
Module: sha_block_padder

Interface
REQ-001 Parameter ADDR_W, default 16: word-address width of message memory.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse; begin padding a message.
REQ-005 message_addr  input  ADDR_W  word address of first message word.
REQ-006 size  input  32  message length in bytes; sampled with start.
REQ-007 mem_addr  output  ADDR_W  memory read address.
REQ-008 mem_read_data  input  32  read data, valid exactly one cycle after mem_addr.
REQ-009 blk_valid  output  1  blk_data holds a complete padded block.
REQ-010 blk_ready  input  1  consumer accepts block when high with blk_valid.
REQ-011 blk_data  output  512  padded block; word 0 in bits 511:480, big-endian bytes.
REQ-012 blk_last  output  1  high with blk_valid on final block.
REQ-013 num_blocks  output  16  block count of current message, valid from the cycle after start.
REQ-014 busy  output  1  high from the cycle after an accepted start until the final handshake.

Function
REQ-015 num_blocks SHALL equal floor((size*8 + 64) / 512) + 1, computed with widths that do not overflow for any 32-bit size.
REQ-016 Message byte b (0-based) SHALL be byte (b mod 4) of memory word message_addr + b/4, byte 0 being the MSB.
REQ-017 Padded-stream byte b: message byte if b < size; 0x80 if b == size; 0x00 otherwise, except the last 8 bytes of the final block.
REQ-018 The last 8 bytes of the final block SHALL be the 64-bit big-endian bit length {29'b0, size, 3'b0}; word 14 = {29'b0, size[31:29]}, word 15 = {size[28:0], 3'b0}.
REQ-019 Memory SHALL be read only for words holding at least one message byte; all other words are generated without a read.
REQ-020 The state machine SHALL have states IDLE, READ, WAIT, EMIT.
REQ-021 Transitions: IDLE -> READ on start; READ -> WAIT after issuing a read; WAIT -> READ while the block is incomplete; WAIT -> EMIT after the 16th word; EMIT -> READ on handshake of a non-last block; EMIT -> IDLE on handshake with blk_last.
REQ-022 Throughput SHALL be at least one word per two cycles, and at most 34 cycles per block excluding backpressure.
REQ-023 While blk_valid is high and blk_ready is low, blk_data and blk_last SHALL stay stable.
REQ-024 Handshake SHALL occur on any edge where blk_valid and blk_ready are both high; blk_valid SHALL deassert the following cycle.
REQ-025 A start asserted while busy SHALL be ignored.
REQ-026 For size = 0 the block SHALL emit word0 = 32'h80000000, all other words 0, and blk_last = 1.
REQ-027 When the message ends on a word boundary, 0x80 SHALL occupy the MSB of the next word.

Reset
REQ-028 On reset_n low, asynchronously: state IDLE; blk_valid, blk_last, and busy = 0; mem_addr, blk_data, and num_blocks = 0.
REQ-029 Reset mid-message SHALL abandon the message and emit no further blocks; the next start behaves as after power-up.

Configuration
REQ-030 With PADDER_BYTE_SWAP_EN defined, each mem_read_data word SHALL be byte-reversed before use (little-endian memory).
REQ-031 Without PADDER_BYTE_SWAP_EN defined, words SHALL be used as read.

Structure
REQ-032 Package sha_pkg SHALL hold the state enum, BLOCK_WORDS = 16, LEN_BYTES = 8, and a function computing the block count.
REQ-033 Sub-module sha_word_builder SHALL be combinational and form one padded word from the raw word, the word index, size, and the final-block flag.

Verification
REQ-034 size = 120, blk_ready tied high -> num_blocks = 3, three blocks, blk_last on the third, final word15 = 32'h000003C0.
REQ-035 size = 511 -> num_blocks = 9; byte 511 = 0x80; final word15 = 32'h00000FF8.
REQ-036 size = 0 -> one block, word0 = 32'h80000000, words 1-15 = 0, no memory reads.
REQ-037 size = 55 -> 1 block; size = 56 -> 2 blocks, and the second block has words 0-13 = 0 and word15 = 32'h000001C0.
REQ-038 size = 3 with memory word 32'hAABBCCDD -> word0 = 32'hAABBCC80; blk_ready low for 5 cycles -> blk_data unchanged throughout.
REQ-039 reset_n pulsed low during block 2 of a 9-block message -> outputs reset immediately, then a new start with size = 120 yields correct blocks.
